// File: rtl/cav4_sched_pkg.sv
// Shared types and helpers for the cav4 frame sequencer.
// FSM encoding, saturating increment and frame-length clamp.
package cav4_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        REPLAY = 2'd2
    } state_t;

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] clamp_len(
        input logic [7:0] len,
        input logic [7:0] lo
    );
        return (len < lo) ? lo : len;
    endfunction

endpackage

// File: rtl/cav4_frame_gen.sv
// I/Q interleave strobe, pair counter and frame start pulse.
// Frame length is clamped and latched once per frame.
import cav4_sched_pkg::*;

module cav4_frame_gen #(
    parameter int min_frame = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] frame_len,
    output logic       iq,
    output logic       start
);

    logic       r_ph;
    logic [7:0] r_pair;
    logic [7:0] r_len;
    logic       w_first;

    assign w_first = ~r_ph & (r_pair == 8'd0);
    assign iq      = reset_n & ~r_ph;
    assign start   = reset_n & w_first;

    // the length latched at frame start governs the wrap of that frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ph   <= 1'b0;
            r_pair <= 8'd0;
            r_len  <= 8'(min_frame);
        end else begin
            r_ph <= ~r_ph;
            if (w_first)
                r_len <= clamp_len(frame_len, 8'(min_frame));
            if (r_ph) begin
                if (r_pair == r_len - 8'd1)
                    r_pair <= 8'd0;
                else
                    r_pair <= r_pair + 8'd1;
            end
        end
    end

endmodule

// File: rtl/cav4_sched.sv
// Frame sequencer with staged, frame-aligned parameter replay.
// Define CAV4_SCHED_STATS_EN for commit_count/overrun statistics.
import cav4_sched_pkg::*;

module cav4_sched #(
    parameter int aw        = 5,
    parameter int dw        = 18,
    parameter int min_frame = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [7:0]    frame_len,
    input  logic          lb_write,
    input  logic [aw-1:0] lb_addr,
    input  logic [dw-1:0] lb_data,
    output logic          lb_ready,
    input  logic          commit,
    output logic          iq,
    output logic          start,
    output logic          live_we,
    output logic [aw-1:0] live_addr,
    output logic [dw-1:0] live_data,
    output logic          busy,
    output logic          done,
    output logic [15:0]   commit_count,
    output logic          overrun
);

    localparam int N = 1 << aw;

    state_t        r_state;
    logic [dw-1:0] r_stage [N];
    logic [N-1:0]  r_dirty;
    logic [aw-1:0] r_k;
    logic          r_last;
    logic          r_we;
    logic [aw-1:0] r_addr;
    logic [dw-1:0] r_data;
    logic          r_done;
    logic          w_iq;
    logic          w_start;
    logic          w_idle;
    logic          w_wr;
    logic          w_busy;
    logic          w_scan;

    cav4_frame_gen #(.min_frame(min_frame)) u_frame (
        .clk      (clk),
        .reset_n  (reset_n),
        .frame_len(frame_len),
        .iq       (w_iq),
        .start    (w_start)
    );

    assign w_idle = (r_state == IDLE);
    assign w_busy = ~w_idle;
    assign w_wr   = lb_write & w_idle;
    // r_k rests at 0 outside replay, so the start cycle scans entry 0
    assign w_scan = ((r_state == ARMED) & w_start)
                  | ((r_state == REPLAY) & ~r_last);

    assign iq        = w_iq;
    assign start     = w_start;
    assign lb_ready  = reset_n & w_idle;
    assign busy      = w_busy;
    assign live_we   = r_we;
    assign live_addr = r_addr;
    assign live_data = r_data;
    assign done      = r_done;

    always_ff @(posedge clk) begin
        if (w_wr)
            r_stage[lb_addr] <= lb_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_dirty <= '0;
            r_k     <= '0;
            r_last  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            if (w_wr)
                r_dirty[lb_addr] <= 1'b1;
            if (w_scan) begin
                r_we           <= r_dirty[r_k];
                r_addr         <= r_k;
                r_data         <= r_stage[r_k];
                r_dirty[r_k]   <= 1'b0;
                r_k            <= r_k + 1'b1;
                r_done         <= &r_k;
                r_last         <= &r_k;
            end else begin
                r_we   <= 1'b0;
                r_addr <= '0;
                r_data <= '0;
                r_done <= 1'b0;
                r_last <= 1'b0;
            end
            unique case (r_state)
                IDLE:    if (commit) r_state <= ARMED;
                ARMED:   if (w_start) r_state <= REPLAY;
                REPLAY:  if (r_last) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef CAV4_SCHED_STATS_EN
    logic [15:0] r_cnt;
    logic        r_ovr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 16'd0;
            r_ovr <= 1'b0;
        end else begin
            if (commit & w_idle)
                r_cnt <= sat16(r_cnt);
            if (commit & w_busy)
                r_ovr <= 1'b1;
        end
    end

    assign commit_count = r_cnt;
    assign overrun      = r_ovr;
`else
    assign commit_count = 16'd0;
    assign overrun      = 1'b0;
`endif

endmodule

// File: tb/tb_cav4_sched.sv
// Directed and random stimulus for cav4_sched against a
// cycle-position reference model of frames and replay.
module tb_cav4_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  frame_len;
    logic        lb_write;
    logic [4:0]  lb_addr;
    logic [17:0] lb_data;
    logic        lb_ready;
    logic        commit;
    logic        iq;
    logic        start;
    logic        live_we;
    logic [4:0]  live_addr;
    logic [17:0] live_data;
    logic        busy;
    logic        done;
    logic [15:0] commit_count;
    logic        overrun;

    cav4_sched dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_len   (frame_len),
        .lb_write    (lb_write),
        .lb_addr     (lb_addr),
        .lb_data     (lb_data),
        .lb_ready    (lb_ready),
        .commit      (commit),
        .iq          (iq),
        .start       (start),
        .live_we     (live_we),
        .live_addr   (live_addr),
        .live_data   (live_data),
        .busy        (busy),
        .done        (done),
        .commit_count(commit_count),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // model: cycle index, position inside frame, frame length in pairs,
    // replay start cycle (-1 none), armed flag, staged data and dirty set
    int          cyc;
    int          pos;
    int          flen;
    int          m_s;
    bit          m_armed;
    bit          m_acc;
    logic [17:0] stage_m [32];
    bit          dirty_m [32];
    int          m_cnt;
    bit          m_ovr;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".iq"}, 32'(iq), 0);
        chk({tag, ".start"}, 32'(start), 0);
        chk({tag, ".lb_ready"}, 32'(lb_ready), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".live_we"}, 32'(live_we), 0);
        chk({tag, ".live_addr"}, 32'(live_addr), 0);
        chk({tag, ".live_data"}, 32'(live_data), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".commit_count"}, 32'(commit_count), 0);
        chk({tag, ".overrun"}, 32'(overrun), 0);
    endtask

    task automatic model_init();
        cyc = 0;
        pos = 0;
        flen = 4;
        m_s = -1;
        m_armed = 0;
        m_cnt = 0;
        m_ovr = 0;
        for (int i = 0; i < 32; i++) dirty_m[i] = 0;
    endtask

    // one clock cycle: check outputs, apply inputs to model, advance
    task automatic tick();
        int t;
        bit e_we, e_done, e_busy, e_rdy;
        int e_addr;
        logic [17:0] e_data;
        #1;
        if (m_s >= 0 && cyc - m_s > 32) m_s = -1;
        if (pos == 0) flen = (frame_len < 8'd4) ? 4 : int'(frame_len);
        if (m_armed && pos == 0) begin
            m_s = cyc;
            m_armed = 0;
        end
        e_we = 0;
        e_done = 0;
        e_addr = 0;
        e_data = '0;
        if (m_s >= 0) begin
            t = cyc - m_s;
            e_busy = 1;
            if (t >= 1) begin
                e_we = dirty_m[t-1];
                e_addr = t - 1;
                e_data = stage_m[t-1];
                dirty_m[t-1] = 0;
            end
            e_done = (t == 32);
        end else begin
            e_busy = m_armed;
        end
        e_rdy = !e_busy;
        chk("iq", 32'(iq), 32'(pos % 2 == 0));
        chk("start", 32'(start), 32'(pos == 0));
        chk("lb_ready", 32'(lb_ready), 32'(e_rdy));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("live_we", 32'(live_we), 32'(e_we));
        chk("done", 32'(done), 32'(e_done));
        if (e_we) begin
            chk("live_addr", 32'(live_addr), 32'(e_addr));
            chk("live_data", 32'(live_data), 32'(e_data));
        end
`ifdef CAV4_SCHED_STATS_EN
        chk("commit_count", 32'(commit_count), 32'(m_cnt));
        chk("overrun", 32'(overrun), 32'(m_ovr));
`else
        chk("commit_count", 32'(commit_count), 0);
        chk("overrun", 32'(overrun), 0);
`endif
        m_acc = e_rdy && lb_write;
        if (m_acc) begin
            stage_m[lb_addr] = lb_data;
            dirty_m[lb_addr] = 1;
        end
        if (commit) begin
            if (e_rdy) begin
                m_armed = 1;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_ovr = 1;
            end
        end
        pos = (pos + 1) % (2 * flen);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset_n = 1'b0;
        frame_len = 8'd10;
        lb_write = 1'b0;
        lb_addr = '0;
        lb_data = '0;
        commit = 1'b0;
        model_init();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        reset_n = 1'b1;
        model_init();
        run(45);

        frame_len = 8'd2;
        run(20);
        frame_len = 8'd6;
        run(40);
        frame_len = 8'd16;
        run(40);

        lb_write = 1'b1;
        lb_addr = 5'd3;
        lb_data = 18'h01234;
        tick();
        lb_addr = 5'd17;
        lb_data = 18'h3FFFF;
        tick();
        lb_write = 1'b0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        run(80);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        run(80);

        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        lb_write = 1'b1;
        lb_addr = 5'd5;
        lb_data = 18'($urandom);
        m_acc = 0;
        for (int i = 0; i < 200 && !m_acc; i++) tick();
        n_chk++;
        assert (m_acc) else begin
            n_fail++;
            $error("FAIL held_write observed=0 expected=1");
        end
        lb_write = 1'b0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        run(80);

        commit = 1'b1;
        tick();
        tick();
        commit = 1'b0;
        run(80);

        for (int i = 0; i < 400; i++) begin
            lb_write = ($urandom % 3) == 0;
            lb_addr = 5'($urandom);
            lb_data = 18'($urandom);
            commit = ($urandom % 12) == 0;
            tick();
        end
        lb_write = 1'b0;
        commit = 1'b0;
        run(80);

        lb_write = 1'b1;
        lb_addr = 5'd9;
        lb_data = 18'h2A5A5;
        commit = 1'b1;
        tick();
        lb_write = 1'b0;
        commit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_s >= 0 && cyc - m_s == 10) break;
            tick();
        end
        n_chk++;
        assert (m_s >= 0 && cyc - m_s == 10) else begin
            n_fail++;
            $error("FAIL reach_k10 observed=%0d expected=10", cyc - m_s);
        end
        #2 reset_n = 1'b0;
        #1 chk_zero("async_reset");
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_init();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        run(80);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
